// File: rtl/mux_select_sequencer_if.sv
// Control bundle between the VGA input-conditioning/sync stage and the
// colour-function multiplexer select sequencer.
//   frame_start  : one-cycle pulse at start of vertical blanking
//   next_btn     : synchronized, debounced button level
//   auto_mode    : 1 = timed auto-advance, 0 = manual button advance
//   enable_mask  : bit i = 1 allows function i to be selected
//   selection    : registered 2-bit mux select
//   sel_changed  : one-cycle pulse when selection takes a new value
//   pending      : manual advance armed, waiting for next frame_start
// master modport drives the inputs (bench / upstream logic), slave modport is
// the sequencer itself.
interface mux_select_sequencer_if;
  logic       frame_start;
  logic       next_btn;
  logic       auto_mode;
  logic [3:0] enable_mask;
  logic [1:0] selection;
  logic       sel_changed;
  logic       pending;

  modport master (
    output frame_start, next_btn, auto_mode, enable_mask,
    input  selection, sel_changed, pending
  );

  modport slave (
    input  frame_start, next_btn, auto_mode, enable_mask,
    output selection, sel_changed, pending
  );
endinterface

// File: rtl/mux_select_sequencer.sv
// Drives the 2-bit select of the VGA colour-function multiplexer. The select
// advances on a button press (manual) or every FRAME_DIV frames (auto), but
// only ever changes on a frame_start cycle so a frame is never split between
// two patterns. Disabled functions are skipped; if the current function gets
// disabled, the select recovers to the next enabled one at the frame boundary.
// Ports:
//   clk   : pixel clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : mux_select_sequencer_if.slave (see interface header)
module mux_select_sequencer #(
  parameter int FRAME_DIV       = 60,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mux_select_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, ARMED} state_e;

  localparam logic [FRAME_CNT_WIDTH-1:0] DIV_M1 = FRAME_CNT_WIDTH'(FRAME_DIV - 1);

  state_e                     state_q, state_d;
  logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       btn_q, btn_d;
  logic [1:0]                 sel_q, sel_d;
  logic                       chg_q, chg_d;

  logic                       press;
  logic                       adv_req;
  logic [2:0]                 nxt;

  // Returns {found, index} of the first enabled function after cur, searching
  // cur+1, cur+2, cur+3 (mod 4). Iterating downwards lets the nearest hit win.
  function automatic logic [2:0] find_next(input logic [1:0] cur,
                                           input logic [3:0] mask);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      sel_q   <= 2'd0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      sel_q   <= sel_d;
      chg_q   <= chg_d;
    end
  end

  always_comb begin
    press   = bus.next_btn & ~btn_q;
    btn_d   = bus.next_btn;
    state_d = state_q;
    cnt_d   = cnt_q;
    adv_req = 1'b0;
    sel_d   = sel_q;
    chg_d   = 1'b0;
    nxt     = find_next(sel_q, bus.enable_mask);

    if (bus.auto_mode) begin
      // Auto mode owns the advance; any armed manual request is discarded.
      state_d = IDLE;
      if (bus.frame_start) begin
        if (cnt_q == DIV_M1) begin
          cnt_d   = '0;
          adv_req = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (press) begin
            if (bus.frame_start) adv_req = 1'b1;
            else                 state_d = ARMED;
          end
        end
        ARMED: begin
          // Further presses are dropped: at most one advance per frame.
          if (bus.frame_start) begin
            adv_req = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (bus.frame_start) begin
      if (bus.enable_mask == 4'b0000) begin
        sel_d = 2'd0;
      end else if (!bus.enable_mask[sel_q] || (adv_req && nxt[2])) begin
        // A nonzero mask with the current bit clear always yields a hit.
        sel_d = nxt[1:0];
      end
      chg_d = (sel_d != sel_q);
    end
  end

  assign bus.selection   = sel_q;
  assign bus.sel_changed = chg_q;
  assign bus.pending     = (state_q == ARMED);

endmodule
